simple_if_slave: RTL and testbench

- Parameterized register-file slave on the team's simple request/acknowledge bus: addr, data_in, data_out, req, req_ack, plus a write strobe.
- Performs single-word reads and writes into an internal register array using a four-phase req/req_ack handshake.
- Acts as the endpoint for bus instances of widths 8/8, 16/16 and 32/32.

---
 rtl/simple_if_slave.sv | 151 +++++++++++++++
 tb/tb_simple_if_slave.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/simple_if_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | simple_if_slave: register-file endpoint on the four-phase req/req_ack bus.  |
// | Optional out-of-range error output: define SIMPLE_IF_OOR_ERR_EN.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module simple_if_slave #(
   parameter int unsigned addr_w     = 8,
   parameter int unsigned data_w     = 8,
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned ACK_LAT    = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [addr_w-1:0] addr,
   input  logic [data_w-1:0] data_in,
   input  logic              we,
   input  logic              req,
   output logic              req_ack,
   output logic [data_w-1:0] data_out
`ifdef SIMPLE_IF_OOR_ERR_EN
   ,
   output logic              err
`endif
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [addr_w-1:0]       addr_q, addr_d;
   logic [data_w-1:0]       wdata_q, wdata_d;
   logic                    we_q, we_d;
   logic                    req_ack_q, req_ack_d;
   logic [data_w-1:0]       data_out_q, data_out_d;
   logic [data_w-1:0]       mem_q [DEPTH];
   logic                    w_mem_we;
   logic                    w_oor;
   logic [DEPTH_LOG2-1:0]   w_idx;
`ifdef SIMPLE_IF_OOR_ERR_EN
   logic                    err_q, err_d;
`endif

   assign w_idx = addr_q[DEPTH_LOG2-1:0];

   // Any set bit above the implemented index range makes the access out of range.
   if (DEPTH_LOG2 < addr_w) begin : g_oor_cmp
      assign w_oor = |addr_q[addr_w-1:DEPTH_LOG2];
   end else begin : g_oor_none
      assign w_oor = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         req_ack_q  <= 1'b0;
         data_out_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
`ifdef SIMPLE_IF_OOR_ERR_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         req_ack_q  <= req_ack_d;
         data_out_q <= data_out_d;
         if (w_mem_we) begin
            mem_q[w_idx] <= wdata_q;
         end
`ifdef SIMPLE_IF_OOR_ERR_EN
         err_q      <= err_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      req_ack_d  = req_ack_q;
      data_out_d = data_out_q;
      w_mem_we   = 1'b0;
`ifdef SIMPLE_IF_OOR_ERR_EN
      err_d      = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d  = addr;
               wdata_d = data_in;
               we_d    = we;
               cnt_d   = 4'(ACK_LAT - 1);
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q == 4'd0) begin
               w_mem_we  = we_q & ~w_oor;
               if (!we_q) begin
                  data_out_d = w_oor ? '0 : mem_q[w_idx];
               end
               req_ack_d = 1'b1;
`ifdef SIMPLE_IF_OOR_ERR_EN
               err_d     = w_oor;
`endif
               state_d   = S_ACK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK: begin
            // A req already low here (dropped during BUSY) yields a one-cycle ack pulse.
            if (!req) begin
               req_ack_d = 1'b0;
`ifdef SIMPLE_IF_OOR_ERR_EN
               err_d     = 1'b0;
`endif
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign req_ack  = req_ack_q;
   assign data_out = data_out_q;
`ifdef SIMPLE_IF_OOR_ERR_EN
   assign err      = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_simple_if_slave.sv
`default_nettype none
// Directed bench for simple_if_slave: four instances (8/8 lat1, lat3, lat4, 32/32).
module tb_simple_if_slave;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn, rst2;
   logic [7:0]  addr;
   logic [31:0] data_in;
   logic        we;
   logic [3:0]  req;
   logic        ack0, ack1, ack2, ack3;
   logic [7:0]  dout0, dout1, dout2;
   logic [31:0] dout3;
   logic [31:0] addr32;
   assign addr32 = {24'd0, addr};
`ifdef SIMPLE_IF_OOR_ERR_EN
   logic        err0, err1, err2, err3, err_m;
`endif

   simple_if_slave #(.addr_w(8), .data_w(8), .DEPTH_LOG2(4), .ACK_LAT(1)) u0 (
      .clk(clk), .resetn(rstn), .addr(addr), .data_in(data_in[7:0]), .we(we),
      .req(req[0]), .req_ack(ack0), .data_out(dout0)
`ifdef SIMPLE_IF_OOR_ERR_EN
      , .err(err0)
`endif
   );
   simple_if_slave #(.addr_w(8), .data_w(8), .DEPTH_LOG2(4), .ACK_LAT(3)) u1 (
      .clk(clk), .resetn(rstn), .addr(addr), .data_in(data_in[7:0]), .we(we),
      .req(req[1]), .req_ack(ack1), .data_out(dout1)
`ifdef SIMPLE_IF_OOR_ERR_EN
      , .err(err1)
`endif
   );
   simple_if_slave #(.addr_w(8), .data_w(8), .DEPTH_LOG2(4), .ACK_LAT(4)) u2 (
      .clk(clk), .resetn(rst2), .addr(addr), .data_in(data_in[7:0]), .we(we),
      .req(req[2]), .req_ack(ack2), .data_out(dout2)
`ifdef SIMPLE_IF_OOR_ERR_EN
      , .err(err2)
`endif
   );
   simple_if_slave #(.addr_w(32), .data_w(32), .DEPTH_LOG2(4), .ACK_LAT(1)) u3 (
      .clk(clk), .resetn(rstn), .addr(addr32), .data_in(data_in), .we(we),
      .req(req[3]), .req_ack(ack3), .data_out(dout3)
`ifdef SIMPLE_IF_OOR_ERR_EN
      , .err(err3)
`endif
   );

   int          sel;
   logic        ack_m;
   logic [31:0] dout_m;
   always_comb begin
      ack_m  = 1'b0;
      dout_m = '0;
`ifdef SIMPLE_IF_OOR_ERR_EN
      err_m  = 1'b0;
`endif
      case (sel)
         0: begin ack_m = ack0; dout_m = {24'd0, dout0}; end
         1: begin ack_m = ack1; dout_m = {24'd0, dout1}; end
         2: begin ack_m = ack2; dout_m = {24'd0, dout2}; end
         3: begin ack_m = ack3; dout_m = dout3; end
         default: ;
      endcase
`ifdef SIMPLE_IF_OOR_ERR_EN
      case (sel)
         0: err_m = err0;
         1: err_m = err1;
         2: err_m = err2;
         3: err_m = err3;
         default: ;
      endcase
`endif
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One full four-phase transaction on instance s, checking latency, data, hold and release.
   task automatic xfer(input int s, input logic w, input logic [7:0] a, input logic [31:0] d,
                       input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
      int   lat;
      logic got;
      sel = s;
      @(negedge clk);
      addr = a; data_in = d; we = w; req[s] = 1'b1;
      @(posedge clk); #1;
      chk("ack_low_after_accept", 32'(ack_m), 32'd0);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (ack_m) got = 1'b1;
      end
      if (!got) begin
         chk("ack_timeout", 32'd0, 32'd1);
         req[s] = 1'b0;
         return;
      end
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("data_out", dout_m, exp_rd);
`ifdef SIMPLE_IF_OOR_ERR_EN
      chk("err", 32'(err_m), 32'(exp_err));
`else
      if (exp_err) chk("oor_silent_ack", 32'(ack_m), 32'd1);
`endif
      @(negedge clk);
      addr = ~a; data_in = ~d; we = ~w;
      @(posedge clk); #1;
      chk("ack_hold", 32'(ack_m), 32'd1);
      chk("data_out_hold", dout_m, exp_rd);
      @(negedge clk);
      req[s] = 1'b0;
      @(posedge clk); #1;
      chk("ack_drop", 32'(ack_m), 32'd0);
`ifdef SIMPLE_IF_OOR_ERR_EN
      chk("err_drop", 32'(err_m), 32'd0);
`endif
   endtask

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vec [13];

   initial begin
      vec[0]  = '{we:1'b0, addr:8'h03, wdata:32'h00, exp_rd:32'h00, exp_err:1'b0};
      vec[1]  = '{we:1'b1, addr:8'h07, wdata:32'hA5, exp_rd:32'h00, exp_err:1'b0};
      vec[2]  = '{we:1'b0, addr:8'h07, wdata:32'h00, exp_rd:32'hA5, exp_err:1'b0};
      vec[3]  = '{we:1'b1, addr:8'h00, wdata:32'h11, exp_rd:32'hA5, exp_err:1'b0};
      vec[4]  = '{we:1'b1, addr:8'h20, wdata:32'h5A, exp_rd:32'hA5, exp_err:1'b1};
      vec[5]  = '{we:1'b0, addr:8'h20, wdata:32'h00, exp_rd:32'h00, exp_err:1'b1};
      vec[6]  = '{we:1'b0, addr:8'h00, wdata:32'h00, exp_rd:32'h11, exp_err:1'b0};
      vec[7]  = '{we:1'b1, addr:8'h0F, wdata:32'h3C, exp_rd:32'h11, exp_err:1'b0};
      vec[8]  = '{we:1'b0, addr:8'h0F, wdata:32'h00, exp_rd:32'h3C, exp_err:1'b0};
      vec[9]  = '{we:1'b1, addr:8'h10, wdata:32'hFF, exp_rd:32'h3C, exp_err:1'b1};
      vec[10] = '{we:1'b0, addr:8'h00, wdata:32'h00, exp_rd:32'h11, exp_err:1'b0};
      vec[11] = '{we:1'b0, addr:8'h10, wdata:32'h00, exp_rd:32'h00, exp_err:1'b1};
      vec[12] = '{we:1'b0, addr:8'hFF, wdata:32'h00, exp_rd:32'h00, exp_err:1'b1};

      sel = 0; rstn = 1'b0; rst2 = 1'b0; req = '0;
      addr = '0; data_in = '0; we = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ack0", 32'(ack0), 32'd0);
      chk("reset_dout0", {24'd0, dout0}, 32'd0);
      chk("reset_ack3", 32'(ack3), 32'd0);
      chk("reset_dout3", dout3, 32'd0);
      @(negedge clk);
      rstn = 1'b1; rst2 = 1'b1;

      for (int i = 0; i < 13; i++) begin
         xfer(0, vec[i].we, vec[i].addr, vec[i].wdata, 1, vec[i].exp_rd, vec[i].exp_err);
      end

      xfer(1, 1'b0, 8'h01, 32'h00, 3, 32'h00, 1'b0);
      xfer(1, 1'b1, 8'h01, 32'h77, 3, 32'h00, 1'b0);
      xfer(1, 1'b0, 8'h01, 32'h00, 3, 32'h77, 1'b0);

      xfer(3, 1'b1, 8'h0F, 32'hDEADBEEF, 1, 32'h0, 1'b0);
      xfer(3, 1'b0, 8'h0F, 32'h0, 1, 32'hDEADBEEF, 1'b0);

      // req dropped during BUSY, address changed after acceptance
      xfer(2, 1'b1, 8'h02, 32'h5E, 4, 32'h00, 1'b0);
      sel = 2;
      @(negedge clk);
      addr = 8'h02; we = 1'b0; req[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req[2] = 1'b0; addr = 8'h03;
      repeat (3) @(posedge clk);
      #1;
      chk("viol_ack_before", 32'(ack2), 32'd0);
      @(posedge clk); #1;
      chk("viol_ack_pulse", 32'(ack2), 32'd1);
      chk("viol_data", {24'd0, dout2}, 32'h5E);
      @(posedge clk); #1;
      chk("viol_ack_end", 32'(ack2), 32'd0);

      // reset during BUSY loses the write
      @(negedge clk);
      addr = 8'h05; data_in = 32'h99; we = 1'b1; req[2] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst2 = 1'b0;
      #1;
      chk("rst_busy_ack", 32'(ack2), 32'd0);
      chk("rst_busy_dout", {24'd0, dout2}, 32'd0);
      req[2] = 1'b0;
      @(negedge clk);
      rst2 = 1'b1;
      xfer(2, 1'b0, 8'h05, 32'h0, 4, 32'h00, 1'b0);
      xfer(2, 1'b0, 8'h02, 32'h0, 4, 32'h00, 1'b0);

      // reset while acknowledging drops req_ack asynchronously
      @(negedge clk);
      addr = 8'h06; data_in = 32'h42; we = 1'b1; req[2] = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("ack_before_rst", 32'(ack2), 32'd1);
      @(negedge clk);
      rst2 = 1'b0;
      #1;
      chk("rst_ack_async", 32'(ack2), 32'd0);
      req[2] = 1'b0;
      @(negedge clk);
      rst2 = 1'b1;
      xfer(2, 1'b0, 8'h06, 32'h0, 4, 32'h00, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
